// File: rtl/jk_drive_check_if.sv
// Bundle of the driver/checker's run-control, flop-drive and result signals.
// JK_DRV_ABORT_EN adds the abort request line.
interface jk_drive_check_if #(
  parameter int PAT_LEN = 8,
  parameter int CW      = 8
);
  localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic                 start;
  logic [2*PAT_LEN-1:0] pattern;
  logic                 q_dut;
  logic                 j;
  logic                 k;
  logic                 dut_clr;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CW-1:0]        err_cnt;
  logic [IW-1:0]        first_err_idx;
`ifdef JK_DRV_ABORT_EN
  logic                 abort;

  modport master (
    output start, pattern, q_dut, abort,
    input  j, k, dut_clr, busy, done, pass, err_cnt, first_err_idx
  );
  modport slave (
    input  start, pattern, q_dut, abort,
    output j, k, dut_clr, busy, done, pass, err_cnt, first_err_idx
  );
`else
  modport master (
    output start, pattern, q_dut,
    input  j, k, dut_clr, busy, done, pass, err_cnt, first_err_idx
  );
  modport slave (
    input  start, pattern, q_dut,
    output j, k, dut_clr, busy, done, pass, err_cnt, first_err_idx
  );
`endif
endinterface

// File: rtl/jk_drive_check.sv
// Drives a loaded J/K pattern into an external JK flop and checks its Q against a model.
// Optional feature macro: JK_DRV_ABORT_EN (adds abort input on the interface).
module jk_drive_check #(
  parameter int PAT_LEN    = 8,
  parameter int CLR_CYCLES = 2,
  parameter int CW         = 8
) (
  input logic             clk,
  input logic             reset,
  jk_drive_check_if.slave bus
);
  localparam int IW   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int MAXC = (PAT_LEN > CLR_CYCLES) ? PAT_LEN : CLR_CYCLES;
  localparam int CNTW = $clog2(MAXC + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PAT_LEN-1:0][1:0]  shadow_q, shadow_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     j_q, j_d;
  logic                     k_q, k_d;
  logic                     clr_q, clr_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [CW-1:0]            err_q, err_d;
  logic [IW-1:0]            fidx_q, fidx_d;
  logic                     q_exp_q, q_exp_d;
  logic                     drv_vld_q, drv_vld_d;
  logic [IW-1:0]            drv_idx_q, drv_idx_d;
  logic                     cmp_vld_q, cmp_vld_d;
  logic [IW-1:0]            cmp_idx_q, cmp_idx_d;
  logic                     aborted_q, aborted_d;
  logic [1:0]               step_code;

  assign step_code = shadow_q[cnt_q[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      j_q       <= 1'b0;
      k_q       <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fidx_q    <= '0;
      q_exp_q   <= 1'b0;
      drv_vld_q <= 1'b0;
      drv_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      q_exp_q   <= q_exp_d;
      drv_vld_q <= drv_vld_d;
      drv_idx_q <= drv_idx_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    j_d       = 1'b0;
    k_d       = 1'b0;
    clr_d     = 1'b0;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    aborted_d = aborted_q;
    drv_vld_d = 1'b0;
    drv_idx_d = drv_idx_q;
    // Two-stage tag: a step drives at t, the flop updates at t+1, compare at t+2.
    cmp_vld_d = drv_vld_q;
    cmp_idx_d = drv_idx_q;

    unique case ({j_q, k_q})
      2'b00:   q_exp_d = q_exp_q;
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      default: q_exp_d = ~q_exp_q;
    endcase

    if (cmp_vld_q && (bus.q_dut != q_exp_q)) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) fidx_d = cmp_idx_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shadow_d  = bus.pattern;
          err_d     = '0;
          pass_d    = 1'b0;
          fidx_d    = '0;
          cnt_d     = '0;
          clr_d     = 1'b1;
          aborted_d = 1'b0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        q_exp_d = 1'b0;
        if (cnt_q == CNTW'(CLR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        j_d       = step_code[1];
        k_d       = step_code[0];
        drv_vld_d = 1'b1;
        drv_idx_d = cnt_q[IW-1:0];
        if (cnt_q == CNTW'(PAT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNTW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0) && !aborted_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef JK_DRV_ABORT_EN
    // Abort drops any in-flight compares so nothing is counted after the run ends.
    if (bus.abort && (state_q == S_CLR || state_q == S_RUN || state_q == S_DRAIN)) begin
      state_d   = S_DONE;
      j_d       = 1'b0;
      k_d       = 1'b0;
      clr_d     = 1'b0;
      cnt_d     = '0;
      drv_vld_d = 1'b0;
      cmp_vld_d = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  assign bus.j             = j_q;
  assign bus.k             = k_q;
  assign bus.dut_clr       = clr_q;
  assign bus.busy          = (state_q == S_CLR) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_idx = fidx_q;
endmodule
